// File: rtl/divm_sequencer.sv
// DIVM step sequencer: drives operand-handler step codes, memory reads and divider start.
// Optional divider watchdog enabled by defining DIVM_TIMEOUT_EN.
module divm_sequencer #(
  parameter int unsigned MEM_LAT        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       div_done,
  input  logic       div_zero,
  output logic [2:0] divm_op,
  output logic       mem_rd,
  output logic       div_start,
  output logic       busy,
  output logic       done,
  output logic       div0_exc,
  output logic       timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_ADDR_A, S_WAIT_A, S_READ_A, S_WAIT_B, S_READ_B, S_DIV, S_FINISH
  } state_t;

  localparam logic [3:0] WAIT_LAST = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       first_q, first_d;
  logic       div0_q, div0_d;
`ifdef DIVM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q, wd_d;
  logic        to_q, to_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      first_q <= 1'b0;
      div0_q  <= 1'b0;
`ifdef DIVM_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      first_q <= first_d;
      div0_q  <= div0_d;
`ifdef DIVM_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    first_d = 1'b0;
    div0_d  = div0_q;
`ifdef DIVM_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LATCH;
      S_LATCH:  state_d = S_ADDR_A;
      S_ADDR_A: begin
        wait_d  = '0;
        state_d = (MEM_LAT == 0) ? S_READ_A : S_WAIT_A;
      end
      S_WAIT_A: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_READ_A;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_READ_A: begin
        wait_d  = '0;
        state_d = (MEM_LAT == 0) ? S_READ_B : S_WAIT_B;
      end
      S_WAIT_B: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_READ_B;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_READ_B: begin
        state_d = S_DIV;
        first_d = 1'b1;
`ifdef DIVM_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_DIV: begin
        // divider status is not trusted on the cycle div_start is issued
        if (!first_q && div_zero) begin
          state_d = S_FINISH;
          div0_d  = 1'b1;
        end else if (!first_q && div_done) begin
          state_d = S_FINISH;
        end
`ifdef DIVM_TIMEOUT_EN
        else if (wd_q == TO_LAST) begin
          state_d = S_FINISH;
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      S_FINISH: begin
        state_d = S_IDLE;
        div0_d  = 1'b0;
`ifdef DIVM_TIMEOUT_EN
        to_d    = 1'b0;
`endif
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    divm_op   = 3'd0;
    mem_rd    = 1'b0;
    div_start = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    div0_exc  = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      S_IDLE:   divm_op = 3'd0;
      S_LATCH:  divm_op = 3'd1;
      S_ADDR_A: begin divm_op = 3'd2; mem_rd = 1'b1; end
      S_WAIT_A: begin divm_op = 3'd4; mem_rd = 1'b1; end
      S_READ_A: begin divm_op = 3'd3; mem_rd = 1'b1; end
      S_WAIT_B: begin divm_op = 3'd4; mem_rd = 1'b1; end
      S_READ_B: divm_op = 3'd5;
      S_DIV: begin
        divm_op   = 3'd6;
        div_start = first_q;
      end
      S_FINISH: begin
        divm_op  = 3'd7;
        done     = 1'b1;
        div0_exc = div0_q;
`ifdef DIVM_TIMEOUT_EN
        timeout  = to_q;
`endif
      end
      default:  divm_op = 3'd0;
    endcase
  end

endmodule

// File: tb/tb_divm_sequencer.sv
// Randomized bench for divm_sequencer: two instances (MEM_LAT=1 and MEM_LAT=0) checked
// every cycle against a timeline model counting cycles since the accepted start.
module tb_divm_sequencer;

`ifdef DIVM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TMO = 8;
  localparam int L0  = 1;
  localparam int L1  = 0;

  logic       clk;
  logic       reset;
  logic       st [2];
  logic       dn [2];
  logic       zr [2];
  logic [2:0] op [2];
  logic       mr [2];
  logic       ds [2];
  logic       bz [2];
  logic       dne[2];
  logic       dz [2];
  logic       to [2];

  int n_cmp = 0;
  int n_err = 0;

  divm_sequencer #(.MEM_LAT(L0), .TIMEOUT_CYCLES(TMO)) u_lat1 (
    .clk(clk), .reset(reset), .start(st[0]), .div_done(dn[0]), .div_zero(zr[0]),
    .divm_op(op[0]), .mem_rd(mr[0]), .div_start(ds[0]), .busy(bz[0]), .done(dne[0]),
    .div0_exc(dz[0]), .timeout(to[0])
  );

  divm_sequencer #(.MEM_LAT(L1), .TIMEOUT_CYCLES(TMO)) u_lat0 (
    .clk(clk), .reset(reset), .start(st[1]), .div_done(dn[1]), .div_zero(zr[1]),
    .divm_op(op[1]), .mem_rd(mr[1]), .div_start(ds[1]), .busy(bz[1]), .done(dne[1]),
    .div0_exc(dz[1]), .timeout(to[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? L0 : L1;
  endfunction

  // Model: m_t = cycles since the accepted start (0 = idle); DIV begins at cycle 5+2*lat.
  int m_t  [2];
  bit m_fin[2];
  bit m_d0 [2];
  bit m_to [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_t[i] <= 0; m_fin[i] <= 1'b0; m_d0[i] <= 1'b0; m_to[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int d;
        int k;
        d = 5 + 2 * lat_of(i);
        k = m_t[i] - d;
        if (m_fin[i]) begin
          m_fin[i] <= 1'b0; m_t[i] <= 0; m_d0[i] <= 1'b0; m_to[i] <= 1'b0;
        end else if (m_t[i] == 0) begin
          if (st[i]) m_t[i] <= 1;
        end else if (m_t[i] >= d) begin
          if (k > 0 && zr[i]) begin
            m_fin[i] <= 1'b1; m_d0[i] <= 1'b1;
          end else if (k > 0 && dn[i]) begin
            m_fin[i] <= 1'b1;
          end else if (TO_EN && k + 1 >= TMO) begin
            m_fin[i] <= 1'b1; m_to[i] <= 1'b1;
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  function automatic logic [2:0] exp_op(input int t, input bit fin, input int lat);
    if (fin)                return 3'd7;
    if (t == 0)             return 3'd0;
    if (t == 1)             return 3'd1;
    if (t == 2)             return 3'd2;
    if (t <= 2 + lat)       return 3'd4;
    if (t == 3 + lat)       return 3'd3;
    if (t <= 3 + 2 * lat)   return 3'd4;
    if (t == 4 + 2 * lat)   return 3'd5;
    return 3'd6;
  endfunction

  // {mem_rd, div_start, busy, done, div0_exc, timeout}
  function automatic logic [5:0] exp_flags(input int t, input bit fin, input bit d0,
                                           input bit tmo, input int lat);
    if (fin)    return {1'b0, 1'b0, 1'b1, 1'b1, d0, tmo};
    if (t == 0) return 6'b0;
    return {(t >= 2 && t <= 3 + 2 * lat), (t == 5 + 2 * lat), 1'b1, 1'b0, 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "op_lat1" : "op_lat0", 32'(op[i]), 32'(exp_op(m_t[i], m_fin[i], lat_of(i))));
      check(i == 0 ? "flags_lat1" : "flags_lat0",
            32'({mr[i], ds[i], bz[i], dne[i], dz[i], to[i]}),
            32'(exp_flags(m_t[i], m_fin[i], m_d0[i], m_to[i], lat_of(i))));
    end
  end

  task automatic rand_phase(input int cycles, input int p_st, input int p_dn, input int p_zr);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 99) < p_st);
        dn[i] = ($urandom_range(0, 99) < p_dn);
        zr[i] = ($urandom_range(0, 99) < p_zr);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin st[i] = 1'b0; dn[i] = 1'b0; zr[i] = 1'b0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_op", 32'(op[i]), 32'd0);
      check("rst_busy", 32'(bz[i]), 32'd0);
      check("rst_done", 32'(dne[i]), 32'd0);
    end
    #1 reset = 1'b1;

    // Abandon a sequence mid-WAIT_A with an asynchronous reset
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (m_t[0] == 3) break;
      @(negedge clk);
    end
    check("reach_wait_a", 32'(m_t[0]), 32'd3);
    check("wait_a_op", 32'(op[0]), 32'd4);
    #1 reset = 1'b0;
    #1;
    check("midrst_op", 32'(op[0]), 32'd0);
    check("midrst_busy", 32'(bz[0]), 32'd0);
    check("midrst_memrd", 32'(mr[0]), 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);

    rand_phase(3000, 25, 12, 6);
    rand_phase(1500, 60, 90, 0);
    rand_phase(1500, 15, 3, 0);
    rand_phase(1000, 30, 20, 15);

    for (int i = 0; i < 2; i++) begin st[i] = 1'b0; dn[i] = 1'b1; zr[i] = 1'b0; end
    repeat (30) @(negedge clk);
    for (int i = 0; i < 2; i++) check("end_idle_busy", 32'(bz[i]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
